// File: rtl/sw_alloc_credit_sched_pkg.sv
// rtl/sw_alloc_credit_sched_pkg.sv - shared router constants and credit types for the switch allocator
// Provides: NUM_PORTS, NUM_VC, LOCAL_PORT, CREDIT_MAX, VC_BITS, CNT_BITS,
//           credit_cnt_t, port_vec_t and the is_onehot() destination check.
package sw_alloc_credit_sched_pkg;
  localparam int NUM_PORTS  = 5;
  localparam int NUM_VC     = 4;
  localparam int LOCAL_PORT = NUM_PORTS - 1;
  localparam int CREDIT_MAX = 4;
  localparam int VC_BITS    = $clog2(NUM_VC);
  localparam int CNT_BITS   = $clog2(CREDIT_MAX + 1);

  typedef logic [CNT_BITS-1:0]  credit_cnt_t;
  typedef logic [NUM_PORTS-1:0] port_vec_t;

  // A destination is usable only if exactly one output bit is set.
  function automatic logic is_onehot(port_vec_t v);
    return (v != '0) && ((v & (v - port_vec_t'(1))) == '0);
  endfunction
endpackage

// File: rtl/sw_alloc_credit_sched_rr_arbiter.sv
// rtl/sw_alloc_credit_sched_rr_arbiter.sv - combinational round-robin arbiter
// Ports: req[N] requests, ptr highest-priority index; gnt one-hot winner,
//        gnt_idx winner index, any asserted when some request won.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  logic [IW-1:0] idx;

  // Scan from ptr upward with wrap-around; the first requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/sw_alloc_credit_sched.sv
// rtl/sw_alloc_credit_sched.sv - separable input-first switch allocator with per-output credits
// Ports: clk, reset (async active-low); sa_req/sa_dst_port per input VC;
//        dwnstr_router_increment credit returns per non-local output;
//        sa_allocated_ports/vc_index/vc_read_valid registered grants per input;
//        credit_avail per non-local output; credit_err sticky overflow flag.
module sw_alloc_credit_sched
  import sw_alloc_credit_sched_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_PORTS*NUM_VC-1:0]               sa_req,
  input  logic [NUM_PORTS*NUM_VC-1:0][NUM_PORTS-1:0] sa_dst_port,
  input  logic [NUM_PORTS-2:0]                      dwnstr_router_increment,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]       sa_allocated_ports,
  output logic [NUM_PORTS-1:0][VC_BITS-1:0]         vc_index,
  output logic [NUM_PORTS-1:0]                      vc_read_valid,
  output logic [NUM_PORTS-2:0]                      credit_avail,
  output logic                                      credit_err
);
  localparam int PORT_BITS = $clog2(NUM_PORTS);
  localparam int NL        = NUM_PORTS - 1;

  logic [NUM_PORTS-1:0][VC_BITS-1:0]   in_ptr_q, in_ptr_d;
  logic [NUM_PORTS-1:0][PORT_BITS-1:0] out_ptr_q, out_ptr_d;
  credit_cnt_t [NL-1:0]                credit_q, credit_d;
  logic                                credit_err_q, credit_err_d;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] alloc_q, alloc_d;
  logic [NUM_PORTS-1:0][VC_BITS-1:0]   vc_idx_q, vc_idx_d;
  logic [NUM_PORTS-1:0]                valid_q, valid_d;

  logic [NUM_PORTS*NUM_VC-1:0]         elig;
  logic [NUM_PORTS-1:0][NUM_VC-1:0]    s1_gnt;
  logic [NUM_PORTS-1:0][VC_BITS-1:0]   s1_vc;
  logic [NUM_PORTS-1:0]                s1_any;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] s1_dst;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] s2_req, s2_gnt;  // [output][input]
  logic [NUM_PORTS-1:0][PORT_BITS-1:0] s2_idx;
  logic [NUM_PORTS-1:0]                s2_any;

  always_comb begin
    credit_avail = '0;
    for (int o = 0; o < NL; o++) credit_avail[o] = (credit_q[o] != '0);
  end

  // Eligibility uses the registered count, so a count of 1 admits one grant per edge.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS*NUM_VC; i++) begin
      elig[i] = sa_req[i] && is_onehot(sa_dst_port[i]) &&
                (sa_dst_port[i][LOCAL_PORT] || (|(sa_dst_port[i][NL-1:0] & credit_avail)));
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stage1
    rr_arbiter #(.N(NUM_VC), .IW(VC_BITS)) u_vc_arb (
      .req     (elig[p*NUM_VC +: NUM_VC]),
      .ptr     (in_ptr_q[p]),
      .gnt     (s1_gnt[p]),
      .gnt_idx (s1_vc[p]),
      .any     (s1_any[p])
    );
  end

  always_comb begin
    s1_dst = '0;
    s2_req = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (s1_gnt[p][v]) s1_dst[p] = s1_dst[p] | sa_dst_port[p*NUM_VC+v];
      end
      for (int o = 0; o < NUM_PORTS; o++) s2_req[o][p] = s1_any[p] & s1_dst[p][o];
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_stage2
    rr_arbiter #(.N(NUM_PORTS), .IW(PORT_BITS)) u_port_arb (
      .req     (s2_req[o]),
      .ptr     (out_ptr_q[o]),
      .gnt     (s2_gnt[o]),
      .gnt_idx (s2_idx[o]),
      .any     (s2_any[o])
    );
  end

  always_comb begin
    in_ptr_d     = in_ptr_q;
    out_ptr_d    = out_ptr_q;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    alloc_d      = '0;
    vc_idx_d     = '0;
    valid_d      = '0;
    // Only a final grant moves in_ptr; a stage-1 winner that loses keeps its priority.
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int o = 0; o < NUM_PORTS; o++) alloc_d[p][o] = s2_gnt[o][p];
      valid_d[p] = |alloc_d[p];
      if (valid_d[p]) begin
        vc_idx_d[p] = s1_vc[p];
        in_ptr_d[p] = (s1_vc[p] == VC_BITS'(NUM_VC-1)) ? '0 : s1_vc[p] + VC_BITS'(1);
      end
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (s2_any[o]) begin
        out_ptr_d[o] = (s2_idx[o] == PORT_BITS'(NUM_PORTS-1)) ? '0 : s2_idx[o] + PORT_BITS'(1);
      end
    end
    // Grant and return in the same cycle cancel; a return at full count is an overflow.
    for (int o = 0; o < NL; o++) begin
      if (dwnstr_router_increment[o] && !s2_any[o]) begin
        if (credit_q[o] == credit_cnt_t'(CREDIT_MAX)) credit_err_d = 1'b1;
        else credit_d[o] = credit_q[o] + credit_cnt_t'(1);
      end else if (!dwnstr_router_increment[o] && s2_any[o]) begin
        credit_d[o] = credit_q[o] - credit_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ptr_q     <= '0;
      out_ptr_q    <= '0;
      credit_q     <= {NL{credit_cnt_t'(CREDIT_MAX)}};
      credit_err_q <= 1'b0;
      alloc_q      <= '0;
      vc_idx_q     <= '0;
      valid_q      <= '0;
    end else begin
      in_ptr_q     <= in_ptr_d;
      out_ptr_q    <= out_ptr_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      alloc_q      <= alloc_d;
      vc_idx_q     <= vc_idx_d;
      valid_q      <= valid_d;
    end
  end

  assign sa_allocated_ports = alloc_q;
  assign vc_index           = vc_idx_q;
  assign vc_read_valid      = valid_q;
  assign credit_err         = credit_err_q;
endmodule
